// File: rtl/write_out_ctrl_if.sv
// rtl/write_out_ctrl_if.sv - handshake bundle between the write-out sequencer and its neighbours
interface write_out_ctrl_if #(
    parameter int MATRIX_BITS = 6
);
    logic                   start;
    logic                   two_sets;
    logic                   stall;
    logic                   sram_write_enable;
    logic [1:0]             data_set;
    logic [MATRIX_BITS-1:0] matrix_index;
    logic                   busy;
    logic                   done;

    modport master (
        output start, two_sets, stall,
        input  sram_write_enable, data_set, matrix_index, busy, done
    );

    modport slave (
        input  start, two_sets, stall,
        output sram_write_enable, data_set, matrix_index, busy, done
    );
endinterface

// File: rtl/write_out_ctrl.sv
// rtl/write_out_ctrl.sv - sequences write_out over every output diagonal of one or two data sets
module write_out_ctrl #(
    parameter int ARRAY_SIZE  = 8,
    parameter int MATRIX_BITS = 6,
    parameter int DRAIN_DELAY = 2
) (
    input  logic             clk,
    input  logic             rst,
    write_out_ctrl_if.slave  bus
);
    localparam int                     NUM_DIAG  = 2 * ARRAY_SIZE - 1;
    localparam logic [MATRIX_BITS-1:0] LAST_DIAG = MATRIX_BITS'(NUM_DIAG - 1);
    localparam logic [3:0]             DLY_LOAD  = 4'(DRAIN_DELAY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_n;
    logic [3:0]             dly_q, dly_n;
    logic [MATRIX_BITS-1:0] diag_q, diag_n;
    logic                   set_q, set_n;
    logic                   two_q, two_n;
    logic                   we_q, we_n;
    logic [1:0]             ds_q, ds_n;
    logic [MATRIX_BITS-1:0] idx_q, idx_n;
    logic                   busy_q, busy_n;
    logic                   done_q, done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            diag_q  <= '0;
            set_q   <= 1'b0;
            two_q   <= 1'b0;
            we_q    <= 1'b0;
            ds_q    <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            dly_q   <= dly_n;
            diag_q  <= diag_n;
            set_q   <= set_n;
            two_q   <= two_n;
            we_q    <= we_n;
            ds_q    <= ds_n;
            idx_q   <= idx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n = state_q;
        dly_n   = dly_q;
        diag_n  = diag_q;
        set_n   = set_q;
        two_n   = two_q;
        we_n    = 1'b0;
        ds_n    = ds_q;
        idx_n   = idx_q;
        busy_n  = busy_q;
        done_n  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    two_n   = bus.two_sets;
                    busy_n  = 1'b1;
                    dly_n   = DLY_LOAD;
                    diag_n  = '0;
                    set_n   = 1'b0;
                    state_n = (DRAIN_DELAY == 0) ? WRITE : WAIT;
                end
            end
            WAIT: begin
                // Leaving on the count of one puts the first write exactly DRAIN_DELAY+1 edges after start.
                dly_n = dly_q - 4'd1;
                if (dly_q <= 4'd1) begin
                    state_n = WRITE;
                end
            end
            WRITE: begin
                if (!bus.stall) begin
                    we_n  = 1'b1;
                    ds_n  = {1'b0, set_q};
                    idx_n = diag_q;
                    if (diag_q == LAST_DIAG) begin
                        diag_n = '0;
                        if (!set_q && two_q) begin
                            set_n = 1'b1;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        diag_n = diag_q + MATRIX_BITS'(1);
                    end
                end
            end
            DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.sram_write_enable = we_q;
    assign bus.data_set          = ds_q;
    assign bus.matrix_index      = idx_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
endmodule

// File: tb/tb_write_out_ctrl.sv
// tb/tb_write_out_ctrl.sv - three drain-delay variants driven in lockstep against a write-schedule model
module tb_write_out_ctrl;
    localparam int NUM_DIAG = 15;
    localparam int DDS [3] = '{2, 0, 15};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic two_sets = 1'b0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    write_out_ctrl_if #(.MATRIX_BITS(6)) if0 ();
    write_out_ctrl_if #(.MATRIX_BITS(6)) if1 ();
    write_out_ctrl_if #(.MATRIX_BITS(6)) if2 ();

    assign if0.start = start;  assign if0.two_sets = two_sets;  assign if0.stall = stall;
    assign if1.start = start;  assign if1.two_sets = two_sets;  assign if1.stall = stall;
    assign if2.start = start;  assign if2.two_sets = two_sets;  assign if2.stall = stall;

    write_out_ctrl #(.ARRAY_SIZE(8), .MATRIX_BITS(6), .DRAIN_DELAY(2))  u0 (.clk(clk), .rst(rst), .bus(if0));
    write_out_ctrl #(.ARRAY_SIZE(8), .MATRIX_BITS(6), .DRAIN_DELAY(0))  u1 (.clk(clk), .rst(rst), .bus(if1));
    write_out_ctrl #(.ARRAY_SIZE(8), .MATRIX_BITS(6), .DRAIN_DELAY(15)) u2 (.clk(clk), .rst(rst), .bus(if2));

    // {busy, done, we, data_set[1:0], matrix_index[5:0]}
    logic [10:0] obs [3];
    assign obs[0] = {if0.busy, if0.done, if0.sram_write_enable, if0.data_set, if0.matrix_index};
    assign obs[1] = {if1.busy, if1.done, if1.sram_write_enable, if1.data_set, if1.matrix_index};
    assign obs[2] = {if2.busy, if2.done, if2.sram_write_enable, if2.data_set, if2.matrix_index};

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Model: a pass is a list of writes numbered 0..total-1, issued on the first non-stalled
    // edges from accept+1+delay onward; write n carries set n/15 and diagonal n%15.
    bit         m_active    [3];
    int         m_acc       [3];
    int         m_total     [3];
    int         m_issued    [3];
    int         m_done_edge [3];
    int         m_free_edge [3];
    logic       m_busy      [3];
    logic       m_done      [3];
    logic       m_we        [3];
    logic [1:0] m_ds        [3];
    logic [5:0] m_idx       [3];
    int         wr_count    [3];
    int         done_count  [3];

    function automatic logic [10:0] expv(input int i);
        return {m_busy[i], m_done[i], m_we[i], m_ds[i], m_idx[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 1'b0; m_acc[i] = 0; m_total[i] = 0; m_issued[i] = 0;
            m_done_edge[i] = -1; m_free_edge[i] = 0;
            m_busy[i] = 1'b0; m_done[i] = 1'b0; m_we[i] = 1'b0; m_ds[i] = '0; m_idx[i] = '0;
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            wr_count[i] = 0;
            done_count[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            if (m_active[i]) begin
                m_busy[i] = 1'b1;
                m_done[i] = 1'b0;
                if (edge_n >= m_acc[i] + 1 + DDS[i] && !stall) begin
                    m_we[i]  = 1'b1;
                    m_ds[i]  = 2'(m_issued[i] / NUM_DIAG);
                    m_idx[i] = 6'(m_issued[i] % NUM_DIAG);
                    m_issued[i]++;
                    if (m_issued[i] == m_total[i]) begin
                        m_active[i]    = 1'b0;
                        m_done_edge[i] = edge_n + 1;
                        m_free_edge[i] = edge_n + 2;
                    end
                end else begin
                    m_we[i] = 1'b0;
                end
            end else if (start && edge_n >= m_free_edge[i]) begin
                m_active[i] = 1'b1;
                m_acc[i]    = edge_n;
                m_total[i]  = two_sets ? 2 * NUM_DIAG : NUM_DIAG;
                m_issued[i] = 0;
                m_busy[i] = 1'b1; m_we[i] = 1'b0; m_done[i] = 1'b0;
            end else if (edge_n == m_done_edge[i]) begin
                m_done[i] = 1'b1; m_busy[i] = 1'b0; m_we[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0; m_busy[i] = 1'b0; m_we[i] = 1'b0;
            end
        end
    endtask

    task automatic step(input logic s, input logic t, input logic st);
        start = s; two_sets = t; stall = st;
        @(posedge clk);
        edge_n++;
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (obs[i][8] === 1'b1) wr_count[i]++;
            if (obs[i][9] === 1'b1) done_count[i]++;
        end
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== 11'h000) begin
                failures++;
                $display("FAIL reset_state dut%0d got=%h exp=%h", i, obs[i], 11'h000);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_set();
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 55; r++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    failures++;
                    $display("FAIL single_set dut%0d rel=%0d got=%h exp=%h", i, r, obs[i], expv(i));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_count[i] !== 15 || done_count[i] !== 1) begin
                failures++;
                $display("FAIL single_set_counts dut%0d writes=%0d dones=%0d exp 15/1", i, wr_count[i], done_count[i]);
            end
        end
    endtask

    task automatic test_two_sets();
        clear_counts();
        step(1'b1, 1'b1, 1'b0);
        for (int r = 1; r <= 55; r++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    failures++;
                    $display("FAIL two_sets dut%0d rel=%0d got=%h exp=%h", i, r, obs[i], expv(i));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_count[i] !== 30 || done_count[i] !== 1) begin
                failures++;
                $display("FAIL two_sets_counts dut%0d writes=%0d dones=%0d exp 30/1", i, wr_count[i], done_count[i]);
            end
        end
    endtask

    task automatic test_stall();
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 55; r++) begin
            // DUT with delay 2 would issue diagonal 5 at rel edge 8; stall edges 8..10
            step(1'b0, 1'b0, (r >= 8 && r <= 10));
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    failures++;
                    $display("FAIL stall dut%0d rel=%0d got=%h exp=%h", i, r, obs[i], expv(i));
                end
            end
            if (r == 10) begin
                checks++;
                if (obs[0][8] !== 1'b0 || obs[0][5:0] !== 6'd4) begin
                    failures++;
                    $display("FAIL stall_hold we=%b idx=%0d exp we=0 idx=4", obs[0][8], obs[0][5:0]);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_count[i] !== 15 || done_count[i] !== 1) begin
                failures++;
                $display("FAIL stall_counts dut%0d writes=%0d dones=%0d exp 15/1", i, wr_count[i], done_count[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 55; r++) begin
            step((r == 1 || r == 10), 1'b1, 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    failures++;
                    $display("FAIL start_busy dut%0d rel=%0d got=%h exp=%h", i, r, obs[i], expv(i));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_count[i] !== 15 || done_count[i] !== 1) begin
                failures++;
                $display("FAIL start_busy_counts dut%0d writes=%0d dones=%0d exp 15/1", i, wr_count[i], done_count[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 460; r++) begin
            if (r < 400)
                step(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            else
                step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    failures++;
                    $display("FAIL random dut%0d rel=%0d got=%h exp=%h", i, r, obs[i], expv(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        for (int r = 1; r <= 12; r++) begin
            step(1'b0, 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    failures++;
                    $display("FAIL reset_mid_pre dut%0d rel=%0d got=%h exp=%h", i, r, obs[i], expv(i));
                end
            end
        end
        checks++;
        if (obs[0][8] !== 1'b1 || obs[0][5:0] !== 6'd9) begin
            failures++;
            $display("FAIL reset_mid_pos we=%b idx=%0d exp we=1 idx=9", obs[0][8], obs[0][5:0]);
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs[i] !== 11'h000) begin
                failures++;
                $display("FAIL reset_async dut%0d got=%h exp=%h", i, obs[i], 11'h000);
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clear_counts();
        for (int r = 0; r < 80; r++) begin
            step((r == 20), 1'b0, 1'b0);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs[i] !== expv(i)) begin
                    failures++;
                    $display("FAIL reset_mid_post dut%0d rel=%0d got=%h exp=%h", i, r, obs[i], expv(i));
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (wr_count[i] !== 15 || done_count[i] !== 1) begin
                failures++;
                $display("FAIL reset_mid_counts dut%0d writes=%0d dones=%0d exp 15/1", i, wr_count[i], done_count[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_two_sets();
        test_stall();
        test_start_while_busy();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
